// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ControlTypeDefs : shared instruction/ALU-control types for the execute    |
// |                   stage decoder and op sequencer.                          |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
package ControlTypeDefs;

  typedef enum logic [2:0] {
    REG_COMPUTATION = 3'd0,
    IMM_COMPUTATION = 3'd1,
    LOAD            = 3'd2,
    STORE           = 3'd3,
    BRANCH          = 3'd4,
    JUMP            = 3'd5,
    UPPER           = 3'd6,
    TYPE_RESERVED   = 3'd7
  } InstructionTypes;

  // One subtype field shared by R, I, upper and M forms; meaning depends on type.
  typedef logic [3:0] InstructionSubTypes;

  localparam InstructionSubTypes R_ADD  = 4'd0;
  localparam InstructionSubTypes R_SUB  = 4'd1;
  localparam InstructionSubTypes R_SLL  = 4'd2;
  localparam InstructionSubTypes R_SLT  = 4'd3;
  localparam InstructionSubTypes R_SLTU = 4'd4;
  localparam InstructionSubTypes R_XOR  = 4'd5;
  localparam InstructionSubTypes R_SRL  = 4'd6;
  localparam InstructionSubTypes R_SRA  = 4'd7;
  localparam InstructionSubTypes R_OR   = 4'd8;
  localparam InstructionSubTypes R_AND  = 4'd9;
  localparam InstructionSubTypes I_ADDI = 4'd0;

  localparam InstructionSubTypes LOAD_UPPER_IMM = 4'd0;
  localparam InstructionSubTypes ADD_UPPER_PC   = 4'd1;

  localparam InstructionSubTypes M_MUL    = 4'd0;
  localparam InstructionSubTypes M_MULH   = 4'd1;
  localparam InstructionSubTypes M_MULHSU = 4'd2;
  localparam InstructionSubTypes M_MULHU  = 4'd3;
  localparam InstructionSubTypes M_DIV    = 4'd4;
  localparam InstructionSubTypes M_DIVU   = 4'd5;
  localparam InstructionSubTypes M_REM    = 4'd6;
  localparam InstructionSubTypes M_REMU   = 4'd7;

  typedef enum logic [1:0] {
    CLASS_R    = 2'd0,
    CLASS_I    = 2'd1,
    CLASS_M    = 2'd2,
    CLASS_NULL = 2'd3
  } AluClass;

  typedef struct packed {
    AluClass    opClass;
    logic [3:0] code;
  } AluOp;

  localparam AluOp NULL    = '{opClass: CLASS_NULL, code: 4'hF};
  localparam AluOp IMM_ADD = '{opClass: CLASS_I,    code: I_ADDI};
  localparam AluOp SUB     = '{opClass: CLASS_R,    code: R_SUB};
  localparam AluOp NULL_I  = '{opClass: CLASS_I,    code: 4'hF};

  typedef enum logic [1:0] {
    UNIT_ALU  = 2'd0,
    UNIT_MUL  = 2'd1,
    UNIT_DIV  = 2'd2,
    UNIT_NONE = 2'd3
  } AluUnit;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } SeqState;

  function automatic logic isLongUnit(input AluUnit unit);
    return (unit == UNIT_MUL) || (unit == UNIT_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_decode : combinational instruction type/subtype to ALU op and      |
// |                 functional-unit decode table.                              |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module alu_op_decode
  import ControlTypeDefs::*;
(
  input  InstructionTypes    iInstructionType,
  input  InstructionSubTypes iInstructionSubType,
  input  logic               iMulDiv,
  output AluOp               oAluCtrl,
  output AluUnit             oUnit,
  output logic               oIllegal
);

  always_comb begin
    oAluCtrl = NULL;
    oUnit    = UNIT_NONE;
    oIllegal = 1'b0;
    case (iInstructionType)
      REG_COMPUTATION: begin
        if (iMulDiv) begin
          // M ops use the low three subtype bits; bit 2 splits multiply from divide.
          oAluCtrl = '{opClass: CLASS_M, code: {1'b0, iInstructionSubType[2:0]}};
          oUnit    = iInstructionSubType[2] ? UNIT_DIV : UNIT_MUL;
        end else begin
          oAluCtrl = '{opClass: CLASS_R, code: iInstructionSubType};
          oUnit    = UNIT_ALU;
        end
      end
      IMM_COMPUTATION: begin
        oAluCtrl = '{opClass: CLASS_I, code: iInstructionSubType};
        oUnit    = UNIT_ALU;
      end
      LOAD, STORE, JUMP: begin
        oAluCtrl = IMM_ADD;
        oUnit    = UNIT_ALU;
      end
      BRANCH: begin
        oAluCtrl = SUB;
        oUnit    = UNIT_ALU;
      end
      UPPER: begin
        oAluCtrl = (iInstructionSubType == LOAD_UPPER_IMM) ? IMM_ADD : NULL_I;
        oUnit    = UNIT_ALU;
      end
      default: begin
        oAluCtrl = NULL;
        oUnit    = UNIT_NONE;
        oIllegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_sequencer : registered, handshaked ALU-control sequencer; holds     |
// |                    MUL/DIV ops for their latency while back-pressuring.   |
// |                    Optional EXEC-cycle counter: ALU_OP_SEQ_PERF_EN.        |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module alu_op_sequencer
  import ControlTypeDefs::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = $clog2((((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) > 2)
                                 ? ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) : 2)
)(
  input  logic               iClk,
  input  logic               iRstN,
  input  logic               iFlush,
  input  logic               iValid,
  output logic               oReady,
  input  InstructionTypes    iInstructionType,
  input  InstructionSubTypes iInstructionSubType,
  input  logic               iMulDiv,
  output logic               oValid,
  input  logic               iReady,
  output AluOp               oAluCtrl,
  output AluUnit             oUnit,
  output logic               oIllegal,
  output logic               oBusy,
  output logic [31:0]        oStallCycles
);

  localparam logic [CNT_W-1:0] cMulLoad = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] cDivLoad = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);

  AluOp             wDecCtrl;
  AluUnit           wDecUnit;
  logic             wDecIllegal;
  logic             wDecMulti;
  logic             wReady;
  logic             wAccept;

  SeqState          rState,    stateNext;
  logic [CNT_W-1:0] rCnt,      cntNext;
  logic             rValid,    validNext;
  AluOp             rAluCtrl,  ctrlNext;
  AluUnit           rUnit,     unitNext;
  logic             rIllegal,  illNext;
  AluOp             rPendCtrl, pendCtrlNext;
  AluUnit           rPendUnit, pendUnitNext;

  alu_op_decode uDecode (
    .iInstructionType    (iInstructionType),
    .iInstructionSubType (iInstructionSubType),
    .iMulDiv             (iMulDiv),
    .oAluCtrl            (wDecCtrl),
    .oUnit               (wDecUnit),
    .oIllegal            (wDecIllegal)
  );

  assign wReady    = (rState == IDLE) && (!rValid || iReady);
  assign wAccept   = iValid && wReady && !iFlush;
  assign wDecMulti = isLongUnit(wDecUnit) &&
                     ((wDecUnit == UNIT_DIV) ? (DIV_LAT > 1) : (MUL_LAT > 1));

  always_comb begin
    stateNext    = rState;
    cntNext      = rCnt;
    validNext    = rValid;
    ctrlNext     = rAluCtrl;
    unitNext     = rUnit;
    illNext      = rIllegal;
    pendCtrlNext = rPendCtrl;
    pendUnitNext = rPendUnit;
    if (iReady) validNext = 1'b0;
    case (rState)
      IDLE: begin
        if (wAccept) begin
          if (wDecMulti) begin
            // Counter runs LAT-2 .. 0 so the result lands exactly LAT cycles after accept.
            stateNext    = EXEC;
            cntNext      = (wDecUnit == UNIT_DIV) ? cDivLoad : cMulLoad;
            pendCtrlNext = wDecCtrl;
            pendUnitNext = wDecUnit;
          end else begin
            validNext = 1'b1;
            ctrlNext  = wDecCtrl;
            unitNext  = wDecUnit;
            illNext   = wDecIllegal;
          end
        end
      end
      EXEC: begin
        if (rCnt != '0) begin
          cntNext = rCnt - CNT_W'(1);
        end else begin
          stateNext = IDLE;
          validNext = 1'b1;
          ctrlNext  = rPendCtrl;
          unitNext  = rPendUnit;
          illNext   = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (iFlush) begin
      stateNext = IDLE;
      cntNext   = '0;
      validNext = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rState    <= IDLE;
      rCnt      <= '0;
      rValid    <= 1'b0;
      rAluCtrl  <= NULL;
      rUnit     <= UNIT_NONE;
      rIllegal  <= 1'b0;
      rPendCtrl <= NULL;
      rPendUnit <= UNIT_NONE;
    end else begin
      rState    <= stateNext;
      rCnt      <= cntNext;
      rValid    <= validNext;
      rAluCtrl  <= ctrlNext;
      rUnit     <= unitNext;
      rIllegal  <= illNext;
      rPendCtrl <= pendCtrlNext;
      rPendUnit <= pendUnitNext;
    end
  end

  assign oReady   = wReady;
  assign oValid   = rValid;
  assign oAluCtrl = rAluCtrl;
  assign oUnit    = rUnit;
  assign oIllegal = rIllegal;
  assign oBusy    = (rState == EXEC);

`ifdef ALU_OP_SEQ_PERF_EN
  logic [31:0] rStallCycles;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rStallCycles <= '0;
    end else if ((rState == EXEC) && (rStallCycles != 32'hFFFF_FFFF)) begin
      rStallCycles <= rStallCycles + 32'd1;
    end
  end

  assign oStallCycles = rStallCycles;
`else
  assign oStallCycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_op_sequencer : vector table, directed corner cases and random     |
// |                       traffic against a cycle-count reference model.      |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_alu_op_sequencer;
  import ControlTypeDefs::*;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;

  logic               iClk = 1'b0;
  logic               iRstN = 1'b0;
  logic               iFlush = 1'b0;
  logic               iValid = 1'b0;
  logic               iReady = 1'b0;
  logic               iMulDiv = 1'b0;
  InstructionTypes    iInstructionType = REG_COMPUTATION;
  InstructionSubTypes iInstructionSubType = 4'd0;
  logic               oReady, oValid, oIllegal, oBusy;
  AluOp               oAluCtrl;
  AluUnit             oUnit;
  logic [31:0]        oStallCycles;

  int checks = 0;
  int failures = 0;

  always #5 iClk = ~iClk;

  alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .iClk(iClk), .iRstN(iRstN), .iFlush(iFlush), .iValid(iValid), .oReady(oReady),
    .iInstructionType(iInstructionType), .iInstructionSubType(iInstructionSubType),
    .iMulDiv(iMulDiv), .oValid(oValid), .iReady(iReady), .oAluCtrl(oAluCtrl),
    .oUnit(oUnit), .oIllegal(oIllegal), .oBusy(oBusy), .oStallCycles(oStallCycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [3:0] s, input logic m);
    iValid = v;
    iInstructionType = InstructionTypes'(t);
    iInstructionSubType = s;
    iMulDiv = m;
  endtask

  task automatic doReset();
    iRstN = 1'b0; iFlush = 1'b0; iReady = 1'b0;
    drive(1'b0, 3'd0, 4'd0, 1'b0);
    repeat (2) tick();
    iRstN = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] expStall(input logic [31:0] n);
`ifdef ALU_OP_SEQ_PERF_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  // Reference decode from the instruction-class rules; latency in cycles.
  function automatic void refDecode(input logic [2:0] t, input logic [3:0] s, input logic m,
                                    output logic [5:0] ctrl, output logic [1:0] unit,
                                    output logic ill, output int lat);
    ctrl = 6'h3F; unit = 2'd0; ill = 1'b0; lat = 1;
    if (t == 3'd0 && m) begin
      ctrl = {2'b10, 1'b0, s[2:0]};
      if (s[2:0] >= 3'd4) begin unit = 2'd2; lat = DIV_LAT; end
      else begin unit = 2'd1; lat = MUL_LAT; end
    end else if (t == 3'd0) ctrl = {2'b00, s};
    else if (t == 3'd1) ctrl = {2'b01, s};
    else if (t == 3'd2 || t == 3'd3 || t == 3'd5) ctrl = 6'b01_0000;
    else if (t == 3'd4) ctrl = 6'b00_0001;
    else if (t == 3'd6) ctrl = (s == 4'd0) ? 6'b01_0000 : 6'b01_1111;
    else begin unit = 2'd3; ill = 1'b1; end
  endfunction

  // Model: mRemain = cycles until the in-flight result appears (0 = idle).
  int          mRemain;
  logic        mV, mIll;
  logic [5:0]  mCtrl, mPendCtrl;
  logic [1:0]  mUnit, mPendUnit;
  logic [31:0] mStall;

  task automatic modelReset();
    mRemain = 0; mV = 1'b0; mIll = 1'b0; mCtrl = 6'h3F; mUnit = 2'd3;
    mPendCtrl = 6'h3F; mPendUnit = 2'd3; mStall = 0;
  endtask

  function automatic logic modelReady();
    return (mRemain == 0) && (!mV || iReady);
  endfunction

  task automatic modelStep();
    logic [5:0] c; logic [1:0] u; logic il; int lat; logic loaded; logic rdy;
    rdy = modelReady();
    refDecode(iInstructionType, iInstructionSubType, iMulDiv, c, u, il, lat);
    loaded = 1'b0;
    if (mRemain > 0 && mStall != 32'hFFFF_FFFF) mStall++;
    if (iFlush) begin
      mV = 1'b0; mRemain = 0;
    end else begin
      if (mRemain > 0) begin
        mRemain--;
        if (mRemain == 0) begin
          mV = 1'b1; mCtrl = mPendCtrl; mUnit = mPendUnit; mIll = 1'b0; loaded = 1'b1;
        end
      end else if (iValid && rdy) begin
        if (lat == 1) begin
          mV = 1'b1; mCtrl = c; mUnit = u; mIll = il; loaded = 1'b1;
        end else begin
          mRemain = lat - 1; mPendCtrl = c; mPendUnit = u;
        end
      end
      if (!loaded && iReady) mV = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0] t;
    logic [3:0] s;
    logic       m;
    logic [5:0] ctrl;
    logic [1:0] unit;
    logic       ill;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n;
    vecs[0]  = '{3'd4, 4'd0, 1'b0, 6'b00_0001, 2'd0, 1'b0, 1};
    vecs[1]  = '{3'd2, 4'd3, 1'b0, 6'b01_0000, 2'd0, 1'b0, 1};
    vecs[2]  = '{3'd3, 4'd0, 1'b0, 6'b01_0000, 2'd0, 1'b0, 1};
    vecs[3]  = '{3'd5, 4'd0, 1'b0, 6'b01_0000, 2'd0, 1'b0, 1};
    vecs[4]  = '{3'd6, 4'd0, 1'b0, 6'b01_0000, 2'd0, 1'b0, 1};
    vecs[5]  = '{3'd6, 4'd1, 1'b0, 6'b01_1111, 2'd0, 1'b0, 1};
    vecs[6]  = '{3'd0, 4'd5, 1'b0, 6'b00_0101, 2'd0, 1'b0, 1};
    vecs[7]  = '{3'd1, 4'd7, 1'b0, 6'b01_0111, 2'd0, 1'b0, 1};
    vecs[8]  = '{3'd0, 4'd3, 1'b1, 6'b10_0011, 2'd1, 1'b0, MUL_LAT};
    vecs[9]  = '{3'd0, 4'd6, 1'b1, 6'b10_0110, 2'd2, 1'b0, DIV_LAT};
    vecs[10] = '{3'd7, 4'd2, 1'b0, 6'b11_1111, 2'd3, 1'b1, 1};

    // Reset values
    iRstN = 1'b0;
    #2;
    check("rst_busy_async", oBusy, 1'b0);
    doReset();
    check("rst_valid", oValid, 1'b0);
    check("rst_busy", oBusy, 1'b0);
    check("rst_illegal", oIllegal, 1'b0);
    check("rst_ctrl", oAluCtrl, 6'h3F);
    check("rst_unit", oUnit, 2'd3);
    check("rst_stall", oStallCycles, 32'd0);
    check("rst_ready", oReady, 1'b1);

    // Decode table with latency
    iReady = 1'b1;
    for (int i = 0; i < 11; i++) begin
      check("vec_ready", oReady, 1'b1);
      drive(1'b1, vecs[i].t, vecs[i].s, vecs[i].m);
      tick();
      drive(1'b0, 3'd0, 4'd0, 1'b0);
      n = 1;
      while (!oValid && n < 80) begin tick(); n++; end
      check($sformatf("vec%0d_lat", i), n, vecs[i].lat);
      check($sformatf("vec%0d_valid", i), oValid, 1'b1);
      check($sformatf("vec%0d_ctrl", i), oAluCtrl, vecs[i].ctrl);
      check($sformatf("vec%0d_unit", i), oUnit, vecs[i].unit);
      check($sformatf("vec%0d_ill", i), oIllegal, vecs[i].ill);
      tick();
      check($sformatf("vec%0d_drain", i), oValid, 1'b0);
    end

    // BRANCH then back-to-back LOAD
    doReset();
    iReady = 1'b1;
    drive(1'b1, 3'd4, 4'd0, 1'b0);
    tick();
    check("b2b_valid0", oValid, 1'b1);
    check("b2b_ctrl0", oAluCtrl, 6'b00_0001);
    check("b2b_unit0", oUnit, 2'd0);
    check("b2b_ready0", oReady, 1'b1);
    drive(1'b1, 3'd2, 4'd0, 1'b0);
    tick();
    check("b2b_valid1", oValid, 1'b1);
    check("b2b_ctrl1", oAluCtrl, 6'b01_0000);
    drive(1'b0, 3'd0, 4'd0, 1'b0);
    tick();
    check("b2b_drain", oValid, 1'b0);

    // MUL latency and back-pressure
    drive(1'b1, 3'd0, 4'd0, 1'b1);
    tick();
    drive(1'b0, 3'd0, 4'd0, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      check($sformatf("mul_busy_c%0d", c), oBusy, 1'b1);
      check($sformatf("mul_ready_c%0d", c), oReady, 1'b0);
      check($sformatf("mul_valid_c%0d", c), oValid, 1'b0);
      tick();
    end
    check("mul_valid_c3", oValid, 1'b1);
    check("mul_unit_c3", oUnit, 2'd1);
    check("mul_busy_c3", oBusy, 1'b0);
    tick();

    // DIV completing into a stalled consumer
    doReset();
    iReady = 1'b1;
    drive(1'b1, 3'd0, 4'd4, 1'b1);
    tick();
    drive(1'b0, 3'd0, 4'd0, 1'b0);
    iReady = 1'b0;
    for (int c = 2; c <= 31; c++) tick();
    check("div_c31_valid", oValid, 1'b0);
    check("div_c31_busy", oBusy, 1'b1);
    tick();
    check("div_c32_valid", oValid, 1'b1);
    check("div_c32_unit", oUnit, 2'd2);
    check("div_c32_ready", oReady, 1'b0);
    check("div_c32_busy", oBusy, 1'b0);
    check("div_stall", oStallCycles, expStall(32'd31));
    repeat (3) tick();
    check("div_hold_valid", oValid, 1'b1);
    check("div_hold_ctrl", oAluCtrl, 6'b10_0100);
    check("div_hold_ready", oReady, 1'b0);
    iReady = 1'b1;
    #1;
    check("div_release_ready", oReady, 1'b1);
    tick();
    check("div_release_valid", oValid, 1'b0);

    // Flush mid-DIV, then a new ADD
    doReset();
    iReady = 1'b1;
    drive(1'b1, 3'd0, 4'd5, 1'b1);
    tick();
    drive(1'b0, 3'd0, 4'd0, 1'b0);
    repeat (4) tick();
    iFlush = 1'b1;
    drive(1'b1, 3'd0, 4'd0, 1'b0);
    tick();
    check("flush_busy", oBusy, 1'b0);
    check("flush_valid", oValid, 1'b0);
    check("flush_ready", oReady, 1'b1);
    iFlush = 1'b0;
    tick();
    drive(1'b0, 3'd0, 4'd0, 1'b0);
    check("flush_add_valid", oValid, 1'b1);
    check("flush_add_ctrl", oAluCtrl, 6'b00_0000);
    check("flush_add_unit", oUnit, 2'd0);
    tick();

    // Async reset between edges during EXEC
    drive(1'b1, 3'd0, 4'd7, 1'b1);
    tick();
    drive(1'b0, 3'd0, 4'd0, 1'b0);
    repeat (3) tick();
    check("arst_pre_busy", oBusy, 1'b1);
    #2;
    iRstN = 1'b0;
    #1;
    check("arst_busy", oBusy, 1'b0);
    check("arst_valid", oValid, 1'b0);
    check("arst_ctrl", oAluCtrl, 6'h3F);
    check("arst_unit", oUnit, 2'd3);
    check("arst_stall", oStallCycles, 32'd0);
    #1;
    iRstN = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (oValid) n++;
    end
    check("arst_no_valid", n, 0);

    // Random traffic against the model
    doReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      iReady = ($urandom_range(0, 9) < 7);
      iFlush = ($urandom_range(0, 99) < 4);
      drive($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0);
      #1;
      check("rnd_ready", oReady, modelReady());
      check("rnd_valid", oValid, mV);
      check("rnd_busy", oBusy, mRemain > 0);
      check("rnd_stall", oStallCycles, expStall(mStall));
      if (mV) begin
        check("rnd_ctrl", oAluCtrl, mCtrl);
        check("rnd_unit", oUnit, mUnit);
        check("rnd_ill", oIllegal, mIll);
      end
      modelStep();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
